// File: rtl/tt_sel_seq.sv
// Pad-driven user-module selector with power sequencing: synchronises the control
// pads, steps a {branch, block} address over fitted branches and gates power/enable.
module tt_sel_seq #(
  parameter int              G_X        = 16,
  parameter int              G_Y        = 24,
  parameter logic [G_Y-1:0]  MUX_MASK   = '0,
  parameter int              BLK_W      = 4,
  parameter int              BR_W       = 5,
  parameter int              PG_ON_DLY  = 8,
  parameter int              PG_OFF_DLY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_sel_rst_n,
  input  logic                  ctrl_sel_inc,
  input  logic                  ctrl_ena,
  output logic [BR_W+BLK_W-1:0] sel_addr,
  output logic [BR_W+BLK_W-1:0] pend_addr,
  output logic                  pg_ena,
  output logic                  um_ena,
  output logic                  busy
);

  localparam int AW = BR_W + BLK_W;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    PWR_UP = 2'd1,
    ON     = 2'd2,
    PWR_DN = 2'd3
  } state_t;

  // Lowest branch that has a mux fitted; 0 when every branch is masked.
  function automatic logic [BR_W-1:0] first_br();
    logic [G_Y-1:0] sh;
    first_br = '0;
    for (int i = G_Y - 1; i >= 0; i--) begin
      sh = MUX_MASK >> i;
      if (!sh[0]) first_br = BR_W'(i);
    end
  endfunction

  // Next fitted branch after b, wrapping; scanning downwards keeps the nearest hit.
  function automatic logic [BR_W-1:0] next_br(input int b);
    logic [G_Y-1:0] sh;
    next_br = first_br();
    for (int i = G_Y; i >= 1; i--) begin
      sh = MUX_MASK >> ((b + i) % G_Y);
      if (!sh[0]) next_br = BR_W'((b + i) % G_Y);
    end
  endfunction

  localparam logic [BR_W-1:0]  FIRST_BR = first_br();
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(G_X - 1);
  localparam logic [7:0]       ON_LOAD  = 8'(PG_ON_DLY - 1);
  localparam logic [7:0]       OFF_LOAD = 8'(PG_OFF_DLY - 1);

  // Pad synchronisers: bit 0 sel_rst_n, bit 1 sel_inc, bit 2 ena.
  logic [2:0] pad_s1_reg;
  logic [2:0] pad_s2_reg;
  logic       inc_last_reg;

  logic srn_s;
  logic inc_s;
  logic ena_s;
  logic inc_rise;

  assign srn_s    = pad_s2_reg[0];
  assign inc_s    = pad_s2_reg[1];
  assign ena_s    = pad_s2_reg[2];
  assign inc_rise = inc_s & ~inc_last_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pad_s1_reg   <= '0;
      pad_s2_reg   <= '0;
      inc_last_reg <= 1'b0;
    end else begin
      pad_s1_reg   <= {ctrl_ena, ctrl_sel_inc, ctrl_sel_rst_n};
      pad_s2_reg   <= pad_s1_reg;
      inc_last_reg <= inc_s;
    end
  end

  // Successor-branch lookup, folded to constants per branch.
  logic [BR_W-1:0] nxt_br_tbl [G_Y];

  genvar gi;
  generate
    for (gi = 0; gi < G_Y; gi++) begin : g_nxt_br
      assign nxt_br_tbl[gi] = next_br(gi);
    end
  endgenerate

  // Pending address counter
  logic [AW-1:0]    pend_addr_reg;
  logic [AW-1:0]    pend_addr_next;
  logic [BR_W-1:0]  br_cur;
  logic [BLK_W-1:0] blk_cur;

  assign br_cur  = pend_addr_reg[AW-1:BLK_W];
  assign blk_cur = pend_addr_reg[BLK_W-1:0];

  always_comb begin
    pend_addr_next = pend_addr_reg;
    if (!srn_s) begin
      pend_addr_next = {FIRST_BR, {BLK_W{1'b0}}};
    end else if (inc_rise) begin
      if (blk_cur < BLK_LAST) begin
        pend_addr_next = {br_cur, blk_cur + 1'b1};
      end else begin
        pend_addr_next = {nxt_br_tbl[br_cur], {BLK_W{1'b0}}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_addr_reg <= '0;
    end else begin
      pend_addr_reg <= pend_addr_next;
    end
  end

  // Power sequencer
  state_t        state_reg;
  state_t        state_next;
  logic [7:0]    dly_reg;
  logic [7:0]    dly_next;
  logic [AW-1:0] sel_addr_reg;
  logic [AW-1:0] sel_addr_next;
  logic          pg_ena_reg;
  logic          pg_ena_next;
  logic          um_ena_reg;
  logic          um_ena_next;
  logic          abort;

  // Any loss of request or a moved selection tears the design down.
  assign abort = !ena_s || !srn_s || (pend_addr_reg != sel_addr_reg);

  always_comb begin
    state_next    = state_reg;
    dly_next      = dly_reg;
    sel_addr_next = sel_addr_reg;
    case (state_reg)
      OFF: begin
        if (ena_s && srn_s) begin
          sel_addr_next = pend_addr_reg;
          dly_next      = ON_LOAD;
          state_next    = PWR_UP;
        end
      end
      PWR_UP: begin
        if (abort) begin
          dly_next   = OFF_LOAD;
          state_next = PWR_DN;
        end else if (dly_reg == 8'd0) begin
          state_next = ON;
        end else begin
          dly_next = dly_reg - 8'd1;
        end
      end
      ON: begin
        if (abort) begin
          dly_next   = OFF_LOAD;
          state_next = PWR_DN;
        end
      end
      PWR_DN: begin
        if (dly_reg == 8'd0) begin
          state_next = OFF;
        end else begin
          dly_next = dly_reg - 8'd1;
        end
      end
      default: begin
        state_next = OFF;
      end
    endcase
    // Decoded from the next state so the enables switch on the entry edge.
    pg_ena_next = (state_next != OFF);
    um_ena_next = (state_next == ON);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= OFF;
      dly_reg      <= '0;
      sel_addr_reg <= '0;
      pg_ena_reg   <= 1'b0;
      um_ena_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dly_reg      <= dly_next;
      sel_addr_reg <= sel_addr_next;
      pg_ena_reg   <= pg_ena_next;
      um_ena_reg   <= um_ena_next;
    end
  end

  assign sel_addr  = sel_addr_reg;
  assign pend_addr = pend_addr_reg;
  assign pg_ena    = pg_ena_reg;
  assign um_ena    = um_ena_reg;
  assign busy      = (state_reg == PWR_UP) || (state_reg == PWR_DN);

endmodule

// File: tb/tb_tt_sel_seq.sv
// Directed bench for tt_sel_seq: expectations queued as stimulus is applied and
// popped against DUT outputs; two instances cover different branch masks.
module tb_tt_sel_seq;

  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel_rst_n = 1'b1, sel_inc = 1'b0, ena = 1'b0;
  logic b_sel_rst_n = 1'b1, b_sel_inc = 1'b0, b_ena = 1'b0;

  logic [AW-1:0] sel_addr, pend_addr, b_sel_addr, b_pend_addr;
  logic          pg_ena, um_ena, busy, b_pg_ena, b_um_ena, b_busy;

  always #5 clk = ~clk;

  tt_sel_seq #(.MUX_MASK(24'h000004)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_sel_rst_n(sel_rst_n), .ctrl_sel_inc(sel_inc), .ctrl_ena(ena),
    .sel_addr(sel_addr), .pend_addr(pend_addr),
    .pg_ena(pg_ena), .um_ena(um_ena), .busy(busy)
  );

  tt_sel_seq #(.MUX_MASK(24'h000007)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ctrl_sel_rst_n(b_sel_rst_n), .ctrl_sel_inc(b_sel_inc), .ctrl_ena(b_ena),
    .sel_addr(b_sel_addr), .pend_addr(b_pend_addr),
    .pg_ena(b_pg_ena), .um_ena(b_um_ena), .busy(b_busy)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] ad(input int br, input int blk);
    return 32'(br * 16 + blk);
  endfunction

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      e.tag = "sb_underflow";
      e.val = 32'hDEAD_BEEF;
    end else begin
      e = exp_q.pop_front();
    end
    n_checks++;
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.val);
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pg(input logic v, output int n);
    n = 0;
    while (pg_ena !== v && n < 40) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_um(input logic v, output int n);
    n = 0;
    while (um_ena !== v && n < 40) begin
      step(1);
      n++;
    end
  endtask

  task automatic pulse_a();
    sel_inc = 1'b1;
    step(1);
    sel_inc = 1'b0;
    step(2);
  endtask

  task automatic pulse_b();
    b_sel_inc = 1'b1;
    step(1);
    b_sel_inc = 1'b0;
    step(2);
  endtask

  // Per-cycle invariants: power gate covers enable; selection moves only at power-up.
  logic          rst_smp = 1'b0;
  logic [AW-1:0] sel_prev = '0;
  logic          pg_prev = 1'b0;

  always @(posedge clk) rst_smp = rst_n;

  always @(negedge clk) begin
    n_checks++;
    assert (!(um_ena && !pg_ena) && !(b_um_ena && !b_pg_ena)) n_pass++;
    else $error("FAIL pg_ge_um observed pg=%b um=%b b_pg=%b b_um=%b required pg>=um",
                pg_ena, um_ena, b_pg_ena, b_um_ena);
    if (rst_smp && sel_addr !== sel_prev) begin
      n_checks++;
      assert (pg_ena && !pg_prev) n_pass++;
      else $error("FAIL sel_change observed pg_prev=%b pg=%b required pg rising", pg_prev, pg_ena);
    end
    sel_prev = sel_addr;
    pg_prev  = pg_ena;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic um_seen;

    // Reset state
    step(3);
    push("rst_pg", 0);     chk(32'(pg_ena));
    push("rst_um", 0);     chk(32'(um_ena));
    push("rst_busy", 0);   chk(32'(busy));
    push("rst_sel", 0);    chk(32'(sel_addr));
    push("rst_pend", 0);   chk(32'(pend_addr));
    push("rst_pend_b", 0); chk(32'(b_pend_addr));
    rst_n = 1'b1;
    step(4);

    // 1: selection reset then power-up timing
    sel_rst_n = 1'b0;
    push("t1_pend_rst", ad(0, 0));
    push("t1_pend_b_first", ad(3, 0));
    step(4);
    chk(32'(pend_addr));
    chk(32'(b_pend_addr));
    sel_rst_n = 1'b1;
    step(2);
    ena = 1'b1;
    push("t1_pg_lat", 3);   wait_pg(1'b1, n); chk(32'(n));
    push("t1_busy_up", 1);  chk(32'(busy));
    push("t1_um_up", 0);    chk(32'(um_ena));
    push("t1_um_lat", 8);   wait_um(1'b1, n); chk(32'(n));
    push("t1_sel", 0);      chk(32'(sel_addr));
    push("t1_busy_on", 0);  chk(32'(busy));

    // 3: increment while ON re-selects
    push("t3_pend", ad(0, 1));
    pulse_a();
    chk(32'(pend_addr));
    push("t3_um_fall", 1);  wait_um(1'b0, n); chk(32'(n));
    push("t3_pg_fall", 4);  wait_pg(1'b0, n); chk(32'(n));
    push("t3_off_cyc", 1);  wait_pg(1'b1, n); chk(32'(n));
    push("t3_sel_new", ad(0, 1)); chk(32'(sel_addr));
    push("t3_busy", 1);     chk(32'(busy));
    push("t3_um_lat", 8);   wait_um(1'b1, n); chk(32'(n));

    // 4: ena drops 3 cycles into PWR_UP
    ena = 1'b0;
    push("t4_on_off", 7);   wait_pg(1'b0, n); chk(32'(n));
    step(2);
    ena = 1'b1;
    push("t4_pg_lat", 3);   wait_pg(1'b1, n); chk(32'(n));
    ena = 1'b0;
    push("t4_pg_off", 7);
    push("t4_um_never", 0);
    n = 0;
    um_seen = 1'b0;
    while (pg_ena && n < 40) begin
      step(1);
      n++;
      if (um_ena) um_seen = 1'b1;
    end
    chk(32'(n));
    chk(32'(um_seen));

    // 5: selection reset coincident with an inc edge at {0,5}
    push("t5_pend5", ad(0, 5));
    repeat (4) pulse_a();
    chk(32'(pend_addr));
    ena = 1'b1;
    push("t5_pg_lat", 3);   wait_pg(1'b1, n); chk(32'(n));
    push("t5_um_lat", 8);   wait_um(1'b1, n); chk(32'(n));
    push("t5_sel", ad(0, 5)); chk(32'(sel_addr));
    push("t5_pend_rst", ad(0, 0));
    push("t5_um_dn", 0);
    push("t5_pg_dn", 1);
    push("t5_busy_dn", 1);
    sel_rst_n = 1'b0;
    sel_inc   = 1'b1;
    step(1);
    sel_inc = 1'b0;
    step(2);
    chk(32'(pend_addr));
    chk(32'(um_ena));
    chk(32'(pg_ena));
    chk(32'(busy));
    push("t5_pend_hold", ad(0, 0));
    push("t5_off_held", 0);
    step(8);
    chk(32'(pend_addr));
    chk(32'(pg_ena));
    sel_rst_n = 1'b1;
    push("t5_repow", 3);    wait_pg(1'b1, n); chk(32'(n));
    push("t5_sel0", 0);     chk(32'(sel_addr));
    push("t5_um_lat", 8);   wait_um(1'b1, n); chk(32'(n));

    // 6: rst_n mid-ON with ena pad held high
    rst_n = 1'b0;
    push("t6_pg", 0); push("t6_um", 0); push("t6_busy", 0);
    push("t6_sel", 0); push("t6_pend", 0);
    step(1);
    chk(32'(pg_ena)); chk(32'(um_ena)); chk(32'(busy));
    chk(32'(sel_addr)); chk(32'(pend_addr));
    rst_n = 1'b1;
    push("t6_repow", 3);    wait_pg(1'b1, n); chk(32'(n));
    push("t6_sel", 0);      chk(32'(sel_addr));

    // 2: branch skip and wrap
    ena = 1'b0;
    push("t2_off", 7);      wait_pg(1'b0, n); chk(32'(n));
    push("t2_at_1_15", ad(1, 15));
    repeat (31) pulse_a();
    chk(32'(pend_addr));
    push("t2_skip", ad(3, 0));
    pulse_a();
    chk(32'(pend_addr));
    push("t2_b_start", ad(3, 0));  chk(32'(b_pend_addr));
    push("t2_b_at_23_15", ad(23, 15));
    repeat (335) pulse_b();
    chk(32'(b_pend_addr));
    push("t2_b_wrap", ad(3, 0));
    pulse_b();
    chk(32'(b_pend_addr));
    push("t2_b_pg", 0);     chk(32'(b_pg_ena));

    push("sb_drained", 0);
    chk(32'(exp_q.size() - 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
